// File: rtl/tx_hex_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tx_hex_arbiter
//  Brief    : Two-requester arbiter that prints an accepted 32-bit word as
//             eight uppercase ASCII hex characters (optionally followed by
//             CR LF) over a valid/ready byte stream to a UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_hex_arbiter #(
  parameter int PRIO_RR = 1,  // 1 = round-robin on ties, 0 = requester 0 wins
  parameter int TERM    = 1   // 1 = append CR LF after the hex digits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  input  logic [31:0] req0_data,
  output logic        req0_rdy,
  input  logic        req1_vld,
  input  logic [31:0] req1_data,
  output logic        req1_rdy,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx,
  output logic        busy,
  output logic        grant
);

  localparam logic [0:0] c_IDLE     = 1'b0;
  localparam logic [0:0] c_SEND     = 1'b1;
  localparam logic [3:0] c_LAST_IDX = (TERM != 0) ? 4'd9 : 4'd7;

  logic [0:0]  r_state;
  logic [3:0]  r_idx;
  logic [31:0] r_data;
  logic        r_grant;
  logic        r_last_grant;

  logic        w_idle;
  logic        w_win;
  logic        w_accept;
  logic        w_last;
  logic [3:0]  w_nib;
  logic [7:0]  w_char;

  assign w_idle = (r_state == c_IDLE);

  // Pick the winner among the valid requesters; on a tie round-robin
  // favours whoever did not own the previous word.
  always_comb begin
    w_win = 1'b0;
    if (req0_vld && req1_vld) begin
      w_win = (PRIO_RR != 0) ? ~r_last_grant : 1'b0;
    end else if (req1_vld) begin
      w_win = 1'b1;
    end
  end

  // Ready is only offered in IDLE, only to the winner, and never in reset.
  assign req0_rdy = w_idle & ~rst & req0_vld & ~w_win;
  assign req1_rdy = w_idle & ~rst & req1_vld &  w_win;
  assign w_accept = req0_rdy | req1_rdy;

  assign w_last = (r_idx == c_LAST_IDX);

  // Select the character for the current index: nibbles MSB first, then CR LF.
  always_comb begin
    w_nib  = r_data[{~r_idx[2:0], 2'b00} +: 4];
    w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                             : (8'h37 + {4'h0, w_nib});
    if (r_idx == 4'd8) begin
      w_char = 8'h0D;
    end else if (r_idx == 4'd9) begin
      w_char = 8'h0A;
    end
  end

  assign busy   = (r_state == c_SEND);
  assign vld_tx = busy;
  assign d_tx   = busy ? w_char : 8'h00;
  assign grant  = r_grant;

  // Word capture on acceptance and character sequencing while sending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_idx        <= 4'd0;
      r_data       <= 32'h0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (r_state == c_IDLE) begin
      if (w_accept) begin
        r_data  <= w_win ? req1_data : req0_data;
        r_grant <= w_win;
        r_idx   <= 4'd0;
        r_state <= c_SEND;
      end
    end else begin
      if (rdy_tx) begin
        if (w_last) begin
          r_state      <= c_IDLE;
          r_idx        <= 4'd0;
          r_last_grant <= r_grant;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/tx_hex_arbiter.md
TX_HEX_ARBITER -- requirements
Module: tx_hex_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_RR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester 0.
REQ-002 The block SHALL have parameter TERM, default 1, meaning 1 = append CR (0x0D) then LF (0x0A) after the eight hex characters.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0_vld  in  1  requester 0 has a word to print.
REQ-006 req0_data  in  32  requester 0 word.
REQ-007 req0_rdy  out  1  requester 0 word accepted when req0_vld and req0_rdy are both high.
REQ-008 req1_vld, req1_data, req1_rdy SHALL have the same directions, widths and meanings for requester 1.
REQ-009 d_tx  out  8  ASCII byte to the UART transmitter.
REQ-010 vld_tx  out  1  d_tx valid.
REQ-011 rdy_tx  in  1  transmitter ready; a byte transfers on any cycle with vld_tx and rdy_tx both high.
REQ-012 busy  out  1  high while a word is being sent.
REQ-013 grant  out  1  index of the requester owning the current or most recent word.

Function
REQ-014 The FSM SHALL have two states: IDLE and SEND, plus a 4-bit character index idx.
REQ-015 In IDLE, reqN_rdy SHALL be high only for the arbitration winner among the valid requesters; both SHALL be low in SEND.
REQ-016 Arbitration when only one reqN_vld is high SHALL pick that requester.
REQ-017 Arbitration when both are high with PRIO_RR=1 SHALL pick the requester other than last_grant; with PRIO_RR=0 it SHALL pick requester 0.
REQ-018 On acceptance, the block SHALL register the data word and grant, set idx=0, and go to SEND.
REQ-019 On acceptance, vld_tx SHALL rise on the next cycle with the first character (one-cycle latency).
REQ-020 For idx 0..7, d_tx SHALL be the ASCII hex of nibble [31-4*idx : 28-4*idx], MSB nibble first.
REQ-021 Hex mapping: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10), uppercase.
REQ-022 With TERM=1, idx 8 SHALL send 0x0D and idx 9 SHALL send 0x0A; the last idx is 9 with TERM=1 and 7 with TERM=0.
REQ-023 On a transfer that is not the last, idx SHALL increment and the next character SHALL be presented on the next cycle.
REQ-024 With rdy_tx held high, the block SHALL send one byte per cycle with no gaps.
REQ-025 While vld_tx=1 and rdy_tx=0, d_tx and vld_tx SHALL hold stable; no byte SHALL be dropped or duplicated.
REQ-026 On transfer of the last character, the block SHALL return to IDLE, set last_grant=grant, and drive vld_tx=0 and busy=0 on the next cycle.
REQ-027 busy SHALL equal (state==SEND).
REQ-028 The minimum gap between words SHALL be one IDLE cycle.
REQ-029 A requester asserting vld during SEND SHALL wait; its data is sampled only at acceptance.

Reset
REQ-030 While rst=1 at a clock edge, the next-cycle values SHALL be: state=IDLE, idx=0, vld_tx=0, d_tx=0x00, busy=0, grant=0, last_grant=1 (requester 0 wins the first tie), req0_rdy=req1_rdy=0.
REQ-031 Reset in mid-SEND SHALL abort the word: remaining characters are discarded, vld_tx=0 the cycle after reset, and no resumption after reset releases.
REQ-032 reqN_rdy SHALL be forced low while rst=1.

Verification
REQ-033 Basic send: req0 word 0x1234ABCD, rdy_tx=1 -> req0_rdy high one cycle, then bytes 31 32 33 34 41 42 43 44 0D 0A on 10 consecutive cycles, then vld_tx=0 and busy=0.
REQ-034 Round-robin ties: PRIO_RR=1 with both vld held for 3 words -> grant order 0,1,0; PRIO_RR=0 with both held -> grants 0,0,0 and req1_rdy never high.
REQ-035 Backpressure: word 0xFEDCBA98 with rdy_tx toggling pseudo-randomly -> received stream exactly 46 45 44 43 42 41 39 38 0D 0A; d_tx unchanged during every stall cycle.
REQ-036 Reset mid-word: rst pulsed after the 3rd transferred byte -> vld_tx=0 and busy=0 next cycle; a following word 0x00000001 starts at 0x30 and sends the full sequence.
REQ-037 TERM=0: word 0x00000000 -> exactly eight 0x30 bytes with no 0x0D/0x0A, then IDLE.
REQ-038 Request during SEND: req1_vld raised at the 2nd character of a req0 word -> req1_rdy low until IDLE; req1 accepted on the first IDLE cycle, and its first byte appears on the following cycle.
